// File: rtl/brlshift_pipe.sv
// Pipelined barrel shifter/rotator (SHL/SHR/SAR/ROL/ROR/PASS) with carry-out and zero flags.
// Latency: STAGES cycles from input transfer to out_vld; sustained throughput one op per cycle.
// Backpressure: per-stage valid with bubble collapse; in_rdy depends only on out_rdy and stage valids.
module brlshift_pipe #(
    parameter int WIDTH  = 32,
    parameter int CNTW   = $clog2(WIDTH),
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] arg,
    input  logic [CNTW-1:0]  cnt,
    input  logic [2:0]       op,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out,
    output logic             flg,
    output logic             zf
);

    // Log-shift levels handled per stage; the last populated stage takes the remainder.
    localparam int LPS = (CNTW + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SHL = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd1;
    localparam logic [2:0] OP_SAR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // Per-stage payload: partial result, shift count, mode and running carry.
    // The count travels whole; each stage only inspects the bits of its own levels.
    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [CNTW-1:0]  cnt;
        logic [2:0]       op;
        logic             cy;
    } stg_t;

    // One log-shift level: shift/rotate by 2^lvl when that count bit is set.
    // The carry is overwritten by every level that actually moves bits, so after
    // the highest set level it holds the last bit shifted or rotated out overall.
    function automatic stg_t apply_level(input stg_t s, input int lvl);
        stg_t r;
        int   sh;
        r  = s;
        sh = 1 << lvl;
        if (s.cnt[lvl]) begin
            case (s.op)
                OP_SHL: begin
                    r.cy  = s.dat[WIDTH-sh];
                    r.dat = s.dat << sh;
                end
                OP_SHR: begin
                    r.cy  = s.dat[sh-1];
                    r.dat = s.dat >> sh;
                end
                OP_SAR: begin
                    r.cy  = s.dat[sh-1];
                    r.dat = $signed(s.dat) >>> sh;
                end
                OP_ROL: begin
                    r.dat = (s.dat << sh) | (s.dat >> (WIDTH-sh));
                    r.cy  = r.dat[0];
                end
                OP_ROR: begin
                    r.dat = (s.dat >> sh) | (s.dat << (WIDTH-sh));
                    r.cy  = r.dat[WIDTH-1];
                end
                default: r = s;
            endcase
        end
        return r;
    endfunction

    stg_t              stg_q [STAGES];
    stg_t              stg_d [STAGES];
    stg_t              src   [STAGES];
    stg_t              res   [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] up_vld;
    logic [STAGES-1:0] ld;
    logic              zf_q;
    logic              zf_d;

    // Load enables ripple back from the sink: a stage loads when empty or when its successor loads.
    always_comb begin
        logic nxt;
        nxt = out_rdy;
        ld  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !vld_q[k] || nxt;
            nxt   = ld[k];
        end
    end

    assign in_rdy = ld[0];

    // Stage inputs: stage 0 takes the operand port, later stages take their predecessor's register.
    always_comb begin
        src[0]    = '{dat: arg, cnt: cnt, op: op, cy: 1'b0};
        up_vld    = '0;
        up_vld[0] = in_vld;
        for (int k = 1; k < STAGES; k++) begin
            src[k]    = stg_q[k-1];
            up_vld[k] = vld_q[k-1];
        end
    end

    // Each stage applies its slice of the log-shift levels to its input.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            res[k] = src[k];
            for (int l = 0; l < CNTW; l++) begin
                if (l >= k * LPS && l < (k + 1) * LPS) begin
                    res[k] = apply_level(res[k], l);
                end
            end
        end
    end

    // Next state: payload only moves on a real transfer so outputs hold while empty or stalled.
    always_comb begin
        vld_d = vld_q;
        zf_d  = zf_q;
        for (int k = 0; k < STAGES; k++) begin
            stg_d[k] = stg_q[k];
            if (ld[k]) begin
                vld_d[k] = up_vld[k];
            end
            if (ld[k] && up_vld[k]) begin
                stg_d[k] = res[k];
            end
        end
        if (ld[STAGES-1] && up_vld[STAGES-1]) begin
            zf_d = (res[STAGES-1].dat == '0);
        end
    end

    // Pipeline registers; reset drops every in-flight operation and clears the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            zf_q  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            zf_q  <= zf_d;
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    assign out_vld = vld_q[STAGES-1];
    assign out     = stg_q[STAGES-1].dat;
    assign flg     = stg_q[STAGES-1].cy;
    assign zf      = zf_q;

endmodule

// File: tb/tb_brlshift_pipe.sv
// Directed-vector bench for brlshift_pipe: a 32-bit/2-stage and an 8-bit/3-stage instance.
module tb_brlshift_pipe;

    localparam int WA = 32;
    localparam int SA = 2;
    localparam int WB = 8;
    localparam int SB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_vld = 1'b0;
    logic        a_in_rdy;
    logic [31:0] a_arg = '0;
    logic [4:0]  a_cnt = '0;
    logic [2:0]  a_op = '0;
    logic        a_out_vld;
    logic        a_out_rdy = 1'b1;
    logic [31:0] a_out;
    logic        a_flg;
    logic        a_zf;

    logic        b_in_vld = 1'b0;
    logic        b_in_rdy;
    logic [7:0]  b_arg = '0;
    logic [2:0]  b_cnt = '0;
    logic [2:0]  b_op = '0;
    logic        b_out_vld;
    logic        b_out_rdy = 1'b1;
    logic [7:0]  b_out;
    logic        b_flg;
    logic        b_zf;

    brlshift_pipe #(.WIDTH(WA), .STAGES(SA)) u_a (
        .clk(clk), .rst_n(rst_n), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
        .arg(a_arg), .cnt(a_cnt), .op(a_op), .out_vld(a_out_vld),
        .out_rdy(a_out_rdy), .out(a_out), .flg(a_flg), .zf(a_zf)
    );

    brlshift_pipe #(.WIDTH(WB), .STAGES(SB)) u_b (
        .clk(clk), .rst_n(rst_n), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
        .arg(b_arg), .cnt(b_cnt), .op(b_op), .out_vld(b_out_vld),
        .out_rdy(b_out_rdy), .out(b_out), .flg(b_flg), .zf(b_zf)
    );

    typedef struct packed {
        logic [31:0] out;
        logic        flg;
        logic        zf;
    } res_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] arg;
        logic [4:0]  cnt;
        logic [31:0] eout;
        logic        eflg;
        logic        ezf;
    } vec_t;

    vec_t vt_a [15];
    vec_t vt_b [9];
    res_t qa [$];
    res_t qb [$];
    res_t pend_a;
    res_t pend_b;

    int vec_n  = 0;
    int bad_n  = 0;
    int acc_a  = 0;
    int outs_a = 0;
    int acc_b  = 0;
    int outs_b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vec_n++;
        if (act !== req) begin
            bad_n++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Step-by-step reference: n single-bit moves, remembering the last bit moved out.
    function automatic logic [64:0] ref_model(input int w, input logic [63:0] a, input int n,
                                              input logic [2:0] op);
        logic [63:0] v;
        logic [63:0] msk;
        logic        c;
        v   = a;
        c   = 1'b0;
        msk = (64'd1 << w) - 64'd1;
        if (op <= 3'd4) begin
            for (int i = 0; i < n; i++) begin
                case (op)
                    3'd0: begin c = v[w-1]; v = (v << 1) & msk; end
                    3'd1: begin c = v[0];   v = v >> 1; end
                    3'd2: begin c = v[0];   v = (v >> 1) | ({63'd0, v[w-1]} << (w - 1)); end
                    3'd3: begin c = v[w-1]; v = ((v << 1) | {63'd0, c}) & msk; end
                    default: begin c = v[0]; v = (v >> 1) | ({63'd0, c} << (w - 1)); end
                endcase
            end
        end
        return {c, v};
    endfunction

    // One clock: sample both DUTs on the falling edge, score outputs, log accepted inputs.
    task automatic cyc();
        res_t e;
        @(negedge clk);
        if (a_out_vld && a_out_rdy) begin
            outs_a++;
            if (qa.size() == 0) begin
                chk("a_unexpected_out", 32'(a_out_vld), 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_out", a_out, e.out);
                chk("a_flg", 32'(a_flg), 32'(e.flg));
                chk("a_zf",  32'(a_zf),  32'(e.zf));
            end
        end
        if (b_out_vld && b_out_rdy) begin
            outs_b++;
            if (qb.size() == 0) begin
                chk("b_unexpected_out", 32'(b_out_vld), 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_out", {24'd0, b_out}, e.out);
                chk("b_flg", 32'(b_flg), 32'(e.flg));
                chk("b_zf",  32'(b_zf),  32'(e.zf));
            end
        end
        if (a_in_vld && a_in_rdy) begin
            qa.push_back(pend_a);
            acc_a++;
        end
        if (b_in_vld && b_in_rdy) begin
            qb.push_back(pend_b);
            acc_b++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input vec_t v);
        a_op   = v.op;
        a_arg  = v.arg;
        a_cnt  = v.cnt;
        pend_a = '{out: v.eout, flg: v.eflg, zf: v.ezf};
    endtask

    task automatic put_b(input vec_t v);
        b_op   = v.op;
        b_arg  = v.arg[7:0];
        b_cnt  = v.cnt[2:0];
        pend_b = '{out: v.eout, flg: v.eflg, zf: v.ezf};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int          lat;
        int          a0;
        int          o0;
        int          k;
        logic [64:0] m;

        //           op     arg            cnt    out            flg   zf
        vt_a[0]  = '{3'd0, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1, 1'b0};
        vt_a[1]  = '{3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vt_a[2]  = '{3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
        vt_a[3]  = '{3'd4, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1, 1'b0};
        vt_a[4]  = '{3'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
        vt_a[5]  = '{3'd1, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b1};
        vt_a[6]  = '{3'd0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1, 1'b0};
        vt_a[7]  = '{3'd3, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 1'b0};
        vt_a[8]  = '{3'd5, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF, 1'b0, 1'b0};
        vt_a[9]  = '{3'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b1};
        vt_a[10] = '{3'd4, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 1'b0};
        vt_a[11] = '{3'd1, 32'hF0F0_F0F0, 5'd5,  32'h0787_8787, 1'b1, 1'b0};
        vt_a[12] = '{3'd0, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_0000, 1'b1, 1'b0};
        vt_a[13] = '{3'd7, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0, 1'b1};
        vt_a[14] = '{3'd3, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};

        vt_b[0]  = '{3'd0, 32'h81, 5'd1, 32'h02, 1'b1, 1'b0};
        vt_b[1]  = '{3'd2, 32'h80, 5'd7, 32'hFF, 1'b0, 1'b0};
        vt_b[2]  = '{3'd1, 32'h80, 5'd7, 32'h01, 1'b0, 1'b0};
        vt_b[3]  = '{3'd4, 32'h01, 5'd1, 32'h80, 1'b1, 1'b0};
        vt_b[4]  = '{3'd3, 32'h5A, 5'd0, 32'h5A, 1'b0, 1'b0};
        vt_b[5]  = '{3'd1, 32'h01, 5'd1, 32'h00, 1'b1, 1'b1};
        vt_b[6]  = '{3'd0, 32'h03, 5'd7, 32'h80, 1'b1, 1'b0};
        vt_b[7]  = '{3'd3, 32'h96, 5'd3, 32'hB4, 1'b0, 1'b0};
        vt_b[8]  = '{3'd4, 32'h96, 5'd3, 32'hD2, 1'b1, 1'b0};

        // Reset state, with reset still asserted.
        #2;
        chk("a_rst_out_vld", 32'(a_out_vld), 32'd0);
        chk("a_rst_out",     a_out,          32'd0);
        chk("a_rst_flg",     32'(a_flg),     32'd0);
        chk("a_rst_zf",      32'(a_zf),      32'd0);
        chk("a_rst_in_rdy",  32'(a_in_rdy),  32'd1);
        chk("b_rst_out_vld", 32'(b_out_vld), 32'd0);
        chk("b_rst_in_rdy",  32'(b_in_rdy),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table, one op at a time, latency measured per op.
        for (int i = 0; i < 15; i++) begin
            put_a(vt_a[i]);
            a_in_vld = 1'b1;
            cyc();
            a_in_vld = 1'b0;
            lat = 0;
            while (qa.size() != 0 && lat < 10) begin
                cyc();
                lat++;
            end
            chk("a_latency", 32'(lat), 32'(SA));
            qa.delete();
        end
        cyc();
        chk("a_idle_out_vld", 32'(a_out_vld), 32'd0);
        chk("a_idle_hold_out", a_out, vt_a[14].eout);

        // Back-to-back random ops against the step model.
        o0 = outs_a;
        for (int i = 0; i < 16; i++) begin
            a_arg  = $urandom;
            a_cnt  = 5'($urandom_range(0, 31));
            a_op   = 3'($urandom_range(0, 7));
            m      = ref_model(WA, {32'd0, a_arg}, int'(a_cnt), a_op);
            pend_a = '{out: m[31:0], flg: m[64], zf: (m[31:0] == 32'd0)};
            chk("a_b2b_in_rdy", 32'(a_in_rdy), 32'd1);
            a_in_vld = 1'b1;
            cyc();
        end
        a_in_vld = 1'b0;
        lat = 0;
        while (qa.size() != 0 && lat < 10) begin
            cyc();
            lat++;
        end
        chk("a_b2b_drain", 32'(lat), 32'(SA));
        chk("a_b2b_count", 32'(outs_a - o0), 32'd16);
        qa.delete();

        // Backpressure: three ops offered against a stalled sink.
        a_out_rdy = 1'b0;
        a0 = acc_a;
        o0 = outs_a;
        for (int i = 0; i < 6; i++) begin
            k = acc_a - a0;
            if (k < 3) begin
                put_a(vt_a[k]);
                a_in_vld = 1'b1;
            end else begin
                a_in_vld = 1'b0;
            end
            cyc();
        end
        chk("a_bp_accepted", 32'(acc_a - a0), 32'(SA));
        chk("a_bp_in_rdy",   32'(a_in_rdy),   32'd0);
        chk("a_bp_out_vld",  32'(a_out_vld),  32'd1);
        chk("a_bp_head_out", a_out,           vt_a[0].eout);
        cyc();
        cyc();
        chk("a_bp_stable_out", a_out,         vt_a[0].eout);
        chk("a_bp_stable_flg", 32'(a_flg),    32'(vt_a[0].eflg));
        chk("a_bp_stable_zf",  32'(a_zf),     32'(vt_a[0].ezf));
        a_out_rdy = 1'b1;
        lat = 0;
        while ((outs_a - o0) < 3 && lat < 12) begin
            k = acc_a - a0;
            if (k < 3) begin
                put_a(vt_a[k]);
                a_in_vld = 1'b1;
            end else begin
                a_in_vld = 1'b0;
            end
            cyc();
            lat++;
        end
        a_in_vld = 1'b0;
        chk("a_bp_released_outs", 32'(outs_a - o0), 32'd3);
        chk("a_bp_total_accepted", 32'(acc_a - a0), 32'd3);
        chk("a_bp_leftover", 32'(qa.size()), 32'd0);
        qa.delete();

        // Reset with two ops in flight.
        put_a(vt_a[12]);
        a_in_vld = 1'b1;
        cyc();
        put_a(vt_a[11]);
        cyc();
        a_in_vld = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("a_midrst_out_vld", 32'(a_out_vld), 32'd0);
        chk("a_midrst_out",     a_out,          32'd0);
        chk("a_midrst_flg",     32'(a_flg),     32'd0);
        chk("a_midrst_zf",      32'(a_zf),      32'd0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        o0 = outs_a;
        for (int i = 0; i < 5; i++) begin
            cyc();
        end
        chk("a_no_stale", 32'(outs_a - o0), 32'd0);

        // 8-bit, 3-stage instance: directed table.
        for (int i = 0; i < 9; i++) begin
            put_b(vt_b[i]);
            b_in_vld = 1'b1;
            cyc();
            b_in_vld = 1'b0;
            lat = 0;
            while (qb.size() != 0 && lat < 10) begin
                cyc();
                lat++;
            end
            chk("b_latency", 32'(lat), 32'(SB));
            qb.delete();
        end

        // 8-bit instance: back-to-back random ops.
        o0 = outs_b;
        for (int i = 0; i < 8; i++) begin
            b_arg  = 8'($urandom);
            b_cnt  = 3'($urandom_range(0, 7));
            b_op   = 3'($urandom_range(0, 7));
            m      = ref_model(WB, {56'd0, b_arg}, int'(b_cnt), b_op);
            pend_b = '{out: {24'd0, m[7:0]}, flg: m[64], zf: (m[7:0] == 8'd0)};
            chk("b_b2b_in_rdy", 32'(b_in_rdy), 32'd1);
            b_in_vld = 1'b1;
            cyc();
        end
        b_in_vld = 1'b0;
        lat = 0;
        while (qb.size() != 0 && lat < 10) begin
            cyc();
            lat++;
        end
        chk("b_b2b_drain", 32'(lat), 32'(SB));
        chk("b_b2b_count", 32'(outs_b - o0), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
        $finish;
    end

endmodule

// File: doc/brlshift_pipe.md
Name: brlshift_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator. It is the next generation of the fixed 8-bit rotate-only shifter.
- Supports five shift/rotate modes with a carry-out flag and a zero flag.
- Uses a valid/ready handshake on both sides, with bubble-collapsing pipeline registers.
- Sits between the decode stage and the ALU writeback path. One operation is accepted per cycle; latency is fixed.

Parameters:
- WIDTH, 32, data width in bits. Power of 2, range 8..64.
- CNTW, $clog2(WIDTH), shift-count width. Derived; do not override.
- STAGES, 2, number of pipeline register stages, range 1..CNTW. The CNTW log-shift levels are split over the stages, ceil(CNTW/STAGES) levels per stage, and the last stage takes the remainder.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_vld  in  1  input operation valid.
- in_rdy  out  1  pipeline can accept an input this cycle.
- arg  in  WIDTH  operand.
- cnt  in  CNTW  shift count, 0..WIDTH-1.
- op  in  3  mode: 000 SHL, 001 SHR, 010 SAR, 011 ROL, 100 ROR, 101..111 PASS.
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts the result.
- out  out  WIDTH  shifted/rotated result.
- flg  out  1  carry: the last bit shifted or rotated out.
- zf  out  1  out == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear, out_vld=0, out=0, flg=0, zf=0.
  - After reset, in_rdy=1 combinationally (the pipe is empty).
  - Reset asserted mid-operation discards all in-flight operations; no partial result is ever presented.
- Transfer rules:
  - Input transfer happens on a cycle where in_vld && in_rdy.
  - Output transfer happens on a cycle where out_vld && out_rdy.
- Per-stage load rule:
  - Stage k loads when its valid bit is 0, or when stage k+1 loads. The last stage counts as "k+1 loads" when out_rdy=1.
  - in_rdy = load enable of stage 0. It is combinational from out_rdy through the stage valid bits; there is no combinational path from in_vld.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_vld, with out_rdy held 1.
  - Sustained throughput is 1 op/cycle.
- Stall behaviour:
  - A stalled stage holds its data and its valid bit.
  - Bubbles collapse: an empty stage accepts data even while later stages stall.
  - Maximum in-flight operations = STAGES.
- Each stage carries its partial result, the remaining cnt bits, op, and a running carry.
- Level i (i=0..CNTW-1) applies a shift of 2^i when cnt[i]=1.
- Mode semantics, with n = cnt:
  - SHL: out = arg << n. flg = arg[WIDTH-n] for n>0.
  - SHR: out = arg >> n, zero fill. flg = arg[n-1] for n>0.
  - SAR: as SHR but fill with arg[WIDTH-1]. flg = arg[n-1].
  - ROL: out = rotate left by n. flg = out[0] for n>0.
  - ROR: out = rotate right by n. flg = out[WIDTH-1] for n>0.
  - PASS: out = arg, flg=0.
- n=0 in any mode: out = arg, flg = 0.
- n=WIDTH-1 boundaries:
  - SHL leaves only arg[0], at the MSB.
  - SAR yields all-sign bits.
- zf is computed from the final out, registered alongside it in the last stage.
- out, flg and zf hold their last values while out_vld=0.
  - They must not change while out_vld=1 && out_rdy=0.
- Simultaneous output transfer and input transfer in the same cycle with a full pipe is legal and keeps throughput 1/cycle.

Test Plan:
- Reset, then SHL arg=0x8000_0001 cnt=1 (WIDTH=32, STAGES=2) -> after 2 cycles: out_vld=1, out=0x0000_0002, flg=1, zf=0.
- SAR arg=0x8000_0000 cnt=31 -> out=0xFFFF_FFFF, flg=0. Then SHR same arg, cnt=31 -> out=0x0000_0001, flg=0.
- ROR arg=0x0000_0001 cnt=1 -> out=0x8000_0000, flg=1. ROL arg=0x1234_5678 cnt=0 -> out=0x1234_5678, flg=0.
- Back-to-back 16 random ops with out_rdy=1 -> one result per cycle, in order, each matching the reference model; SHR arg=0x1 cnt=1 -> out=0, zf=1, flg=1.
- Backpressure:
  - Hold out_rdy=0 with 3 ops offered -> in_rdy drops after STAGES ops accepted; out is stable while stalled.
  - Release out_rdy -> all 3 ops emerge in order with none lost or duplicated.
- Assert rst_n low for 1 cycle with 2 ops in flight -> out_vld=0 and out=0 immediately; no stale result appears after reset release. Repeat the directed ops with WIDTH=8, STAGES=3.
